// File: rtl/reg_file_pkg.sv
// rtl/reg_file_pkg.sv - shared types, defaults and address qualification for the register file
package reg_file_pkg;

  localparam int XLEN_DEF     = 32;
  localparam int NUM_REGS_DEF = 32;

  typedef logic [4:0]  reg_addr_t;
  typedef logic [31:0] xlen_t;

  localparam reg_addr_t ZERO_ADDR = '0;

  // An address is usable when it names a real register and is not the hardwired zero register
  function automatic logic addr_ok(input logic [31:0] addr, input int num_regs, input bit zero_reg);
    return (addr < 32'(num_regs)) && !(zero_reg && (addr == 32'(ZERO_ADDR)));
  endfunction

endpackage

// File: rtl/reg_file_mp_if.sv
// rtl/reg_file_mp_if.sv - read, write and scoreboard-set bus of the multi-port register file
interface reg_file_mp_if #(
  parameter int XLEN     = 32,
  parameter int NUM_REGS = 32,
  parameter int NUM_RD   = 2,
  parameter int NUM_WR   = 1
);

  localparam int AW = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;

  logic [NUM_RD-1:0]           rs_en;
  logic [NUM_RD-1:0][AW-1:0]   rs_addr;
  logic [NUM_RD-1:0][XLEN-1:0] rs_data;
  logic [NUM_RD-1:0]           rs_busy;
  logic [NUM_WR-1:0]           rd_en;
  logic [NUM_WR-1:0][AW-1:0]   rd_addr;
  logic [NUM_WR-1:0][XLEN-1:0] rd_data;
  logic                        sb_set_en;
  logic [AW-1:0]               sb_set_addr;

  modport master (
    output rs_en, rs_addr, rd_en, rd_addr, rd_data, sb_set_en, sb_set_addr,
    input  rs_data, rs_busy
  );

  modport slave (
    input  rs_en, rs_addr, rd_en, rd_addr, rd_data, sb_set_en, sb_set_addr,
    output rs_data, rs_busy
  );

endinterface

// File: rtl/reg_file_rd_port.sv
// rtl/reg_file_rd_port.sv - one registered read port with write forwarding and busy lookup
module reg_file_rd_port
  import reg_file_pkg::*;
#(
  parameter int XLEN     = 32,
  parameter int NUM_REGS = 32,
  parameter int NUM_WR   = 1,
  parameter int BYPASS   = 1,
  parameter int ZERO_REG = 1,
  parameter int AW       = 5
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        rs_en_i,
  input  logic [AW-1:0]               rs_addr_i,
  input  logic [XLEN-1:0]             stor_data_i,
  input  logic                        stor_busy_i,
  input  logic [NUM_WR-1:0]           wr_ok_i,
  input  logic [NUM_WR-1:0][AW-1:0]   wr_addr_i,
  input  logic [NUM_WR-1:0][XLEN-1:0] wr_data_i,
  input  logic                        set_ok_i,
  input  logic [AW-1:0]               set_addr_i,
  output logic [XLEN-1:0]             rs_data_o,
  output logic                        rs_busy_o
);

  logic            rd_ok;
  logic            hit;
  logic [XLEN-1:0] hit_data;
  logic [XLEN-1:0] rs_data_d, rs_data_q;
  logic            rs_busy_d, rs_busy_q;

  // Qualify the read, find the winning same-cycle write (last match = highest port) and pick the result
  always_comb begin
    rd_ok     = rs_en_i && addr_ok(32'(rs_addr_i), NUM_REGS, ZERO_REG != 0);
    hit       = 1'b0;
    hit_data  = '0;
    rs_data_d = '0;
    rs_busy_d = 1'b0;
    for (int w = 0; w < NUM_WR; w++) begin
      if (wr_ok_i[w] && (wr_addr_i[w] == rs_addr_i)) begin
        hit      = 1'b1;
        hit_data = wr_data_i[w];
      end
    end
    if (rd_ok) begin
      rs_data_d = (BYPASS != 0 && hit) ? hit_data : stor_data_i;
      if (BYPASS != 0 && set_ok_i && (set_addr_i == rs_addr_i)) begin
        rs_busy_d = 1'b1;
      end else if (BYPASS != 0 && hit) begin
        rs_busy_d = 1'b0;
      end else begin
        rs_busy_d = stor_busy_i;
      end
    end
  end

  // Output flops; reset forces a clean zero response
  always_ff @(posedge clk) begin
    if (reset) begin
      rs_data_q <= '0;
      rs_busy_q <= 1'b0;
    end else begin
      rs_data_q <= rs_data_d;
      rs_busy_q <= rs_busy_d;
    end
  end

  assign rs_data_o = rs_data_q;
  assign rs_busy_o = rs_busy_q;

endmodule

// File: rtl/reg_file_mp.sv
// rtl/reg_file_mp.sv - multi-port integer register file with bypass and busy scoreboard
module reg_file_mp
  import reg_file_pkg::*;
#(
  parameter int XLEN     = XLEN_DEF,
  parameter int NUM_REGS = NUM_REGS_DEF,
  parameter int NUM_RD   = 2,
  parameter int NUM_WR   = 1,
  parameter int BYPASS   = 1,
  parameter int ZERO_REG = 1
) (
  input logic          clk,
  input logic          reset,
  reg_file_mp_if.slave bus
);

  localparam int AW = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;

  logic [NUM_REGS-1:0][XLEN-1:0] regs_q, regs_d;
  logic [NUM_REGS-1:0]           busy_q, busy_d;
  logic [NUM_WR-1:0]             wr_ok;
  logic                          set_ok;
  logic [NUM_RD-1:0][XLEN-1:0]   rs_data_w;
  logic [NUM_RD-1:0]             rs_busy_w;

  // Decide which writes and which scoreboard set actually land this cycle
  always_comb begin
    wr_ok = '0;
    for (int w = 0; w < NUM_WR; w++) begin
      wr_ok[w] = bus.rd_en[w] && addr_ok(32'(bus.rd_addr[w]), NUM_REGS, ZERO_REG != 0);
    end
    set_ok = bus.sb_set_en && addr_ok(32'(bus.sb_set_addr), NUM_REGS, ZERO_REG != 0);
  end

  // Ascending write order lets the highest port win; the set is applied last so it beats a clear
  always_comb begin
    regs_d = regs_q;
    busy_d = busy_q;
    for (int w = 0; w < NUM_WR; w++) begin
      if (wr_ok[w]) begin
        regs_d[bus.rd_addr[w]] = bus.rd_data[w];
        busy_d[bus.rd_addr[w]] = 1'b0;
      end
    end
    if (set_ok) begin
      busy_d[bus.sb_set_addr] = 1'b1;
    end
  end

  // Storage and scoreboard state
  always_ff @(posedge clk) begin
    if (reset) begin
      regs_q <= '0;
      busy_q <= '0;
    end else begin
      regs_q <= regs_d;
      busy_q <= busy_d;
    end
  end

  for (genvar i = 0; i < NUM_RD; i++) begin : g_rd
    reg_file_rd_port #(
      .XLEN     (XLEN),
      .NUM_REGS (NUM_REGS),
      .NUM_WR   (NUM_WR),
      .BYPASS   (BYPASS),
      .ZERO_REG (ZERO_REG),
      .AW       (AW)
    ) u_rd_port (
      .clk         (clk),
      .reset       (reset),
      .rs_en_i     (bus.rs_en[i]),
      .rs_addr_i   (bus.rs_addr[i]),
      .stor_data_i (regs_q[bus.rs_addr[i]]),
      .stor_busy_i (busy_q[bus.rs_addr[i]]),
      .wr_ok_i     (wr_ok),
      .wr_addr_i   (bus.rd_addr),
      .wr_data_i   (bus.rd_data),
      .set_ok_i    (set_ok),
      .set_addr_i  (bus.sb_set_addr),
      .rs_data_o   (rs_data_w[i]),
      .rs_busy_o   (rs_busy_w[i])
    );
  end

  assign bus.rs_data = rs_data_w;
  assign bus.rs_busy = rs_busy_w;

endmodule
